// File: rtl/ir_pdm_tx_sequencer_if.sv
// Symbol write channel between the host/register block and ir_pdm_tx_sequencer.
// A symbol transfers on every clk edge where wr_valid and wr_ready are both 1; wr_data is meaningful only while wr_valid=1, and a source may drop wr_valid at any time.
interface ir_pdm_tx_sequencer_if;
    logic       wr_valid;
    logic [4:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/ir_pdm_tx_sequencer.sv
// IR PDM transmit sequencer: symbol FIFO, ock/bck dividers and modulator load/done sequencing.
// Optional inter-symbol silence is compiled in with `define IR_SEQ_GAP_EN.
module ir_pdm_tx_sequencer #(
    parameter int DEPTH    = 8,
    parameter int OCK_DIV  = 4,
    parameter int BCK_DIV  = 64,
    parameter int GAP_BCKS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clr_status,
    ir_pdm_tx_sequencer_if.slave       wr,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ock,
    output logic                       bck,
    output logic                       load,
    output logic [4:0]                 sym,
    input  logic                       mod_done,
    output logic                       busy,
    output logic                       underrun,
    output logic [2:0]                 state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int OW = $clog2(OCK_DIV);
    localparam int BW = $clog2(BCK_DIV);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
`ifdef IR_SEQ_GAP_EN
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam int GW = $clog2(GAP_BCKS+1);
`endif

    logic [OW-1:0] ock_cnt;
    logic [BW-1:0] bck_cnt;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    state, state_nxt;
    logic          push, pop, next_sym, decide, set_ur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ock_cnt <= '0;
            ock     <= 1'b0;
        end else if (ock_cnt == OW'(OCK_DIV-1)) begin
            ock_cnt <= '0;
            ock     <= ~ock;
        end else begin
            ock_cnt <= ock_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bck_cnt <= '0;
            bck     <= 1'b0;
        end else if (bck_cnt == BW'(BCK_DIV-1)) begin
            bck_cnt <= '0;
            bck     <= ~bck;
        end else begin
            bck_cnt <= bck_cnt + 1'b1;
        end
    end

    assign wr.wr_ready = (level != LW'(DEPTH));
    assign push        = wr.wr_valid && wr.wr_ready;
    assign pop         = (state == S_LOAD);

    // Storage carries no reset; sym is forced to the null symbol outside LOAD.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

`ifdef IR_SEQ_GAP_EN
    logic          bck_rise;
    logic [GW-1:0] gap_cnt;
    assign bck_rise = (bck_cnt == BW'(BCK_DIV-1)) && !bck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        gap_cnt <= '0;
        else if (state != S_GAP)        gap_cnt <= '0;
        else if (bck_rise)              gap_cnt <= gap_cnt + 1'b1;
    end
`endif

    assign next_sym = enable && (level != '0);

    always_comb begin
        state_nxt = state;
        decide    = 1'b0;
        set_ur    = 1'b0;
        case (state)
            S_IDLE:   if (next_sym) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_WAIT;
`ifdef IR_SEQ_GAP_EN
            S_WAIT:   if (mod_done) state_nxt = S_GAP;
            S_GAP:    decide = bck_rise && (gap_cnt == GW'(GAP_BCKS-1));
`else
            S_WAIT:   decide = mod_done;
`endif
            default:  state_nxt = S_IDLE;
        endcase
        // The end-of-symbol decision is the only place a dry queue counts as underrun.
        if (decide) begin
            state_nxt = next_sym ? S_LOAD : S_IDLE;
            set_ur    = enable && (level == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             underrun <= 1'b0;
        else if (set_ur)     underrun <= 1'b1;
        else if (clr_status) underrun <= 1'b0;
    end

    assign load      = (state == S_LOAD);
    assign sym       = load ? mem[rd_ptr] : 5'h10;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_ir_pdm_tx_sequencer.sv
// Directed bench for ir_pdm_tx_sequencer with a symbol-order scoreboard and a modulator model.
module tb_ir_pdm_tx_sequencer;
    localparam int DEPTH    = 8;
    localparam int OCK_DIV  = 4;
    localparam int BCK_DIV  = 64;
    localparam int GAP_BCKS = 2;
    localparam int LW       = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, clr_status;
    logic [LW-1:0] level;
    logic          ock, bck, load, busy, underrun;
    logic [4:0]    sym;
    logic          mod_done = 1'b1;
    logic [2:0]    state_dbg;

    ir_pdm_tx_sequencer_if wif ();

    ir_pdm_tx_sequencer #(
        .DEPTH(DEPTH), .OCK_DIV(OCK_DIV), .BCK_DIV(BCK_DIV), .GAP_BCKS(GAP_BCKS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
        .wr(wif), .level(level), .ock(ock), .bck(bck), .load(load), .sym(sym),
        .mod_done(mod_done), .busy(busy), .underrun(underrun), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int load_cnt = 0;
    int model_level = 0;
    logic [4:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Modulator model: a null symbol finishes at once, others take 4+sym[2:0] clk.
    int mod_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            mod_cnt  = 0;
            mod_done = 1'b1;
        end else if (load) begin
            if (sym == 5'h10) begin
                mod_cnt  = 0;
                mod_done = 1'b1;
            end else begin
                mod_cnt  = 4 + int'(sym[2:0]);
                mod_done = 1'b0;
            end
        end else if (mod_cnt != 0) begin
            mod_cnt--;
            if (mod_cnt == 0) mod_done = 1'b1;
        end
    end

    // Scoreboard: accepted symbols must come out on load strobes in order.
    always @(negedge clk) begin
        if (rst) begin
            model_level = 0;
            exp_q.delete();
            chk("rst_level", 32'(level), 0);
        end else begin
            int  lvl0;
            logic acc;
            lvl0 = model_level;
            acc  = wif.wr_valid && (lvl0 != DEPTH);
            chk("level", 32'(level), 32'(lvl0));
            chk("wr_ready", 32'(wif.wr_ready), 32'(lvl0 != DEPTH));
            if (load) begin
                load_cnt++;
                chk("load_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sym_order", 32'(sym), 32'(exp_q.pop_front()));
                model_level--;
            end
            if (acc) begin
                exp_q.push_back(wif.wr_data);
                model_level++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] d);
        wif.wr_valid = 1'b1;
        wif.wr_data  = d;
        step();
        wif.wr_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ock"}, 32'(ock), 0);
        chk({tag, "_bck"}, 32'(bck), 0);
        chk({tag, "_load"}, 32'(load), 0);
        chk({tag, "_sym"}, 32'(sym), 32'h10);
        chk({tag, "_wr_ready"}, 32'(wif.wr_ready), 1);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_underrun"}, 32'(underrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0, n, rises;
        logic prev;
        rst = 1'b1; enable = 1'b0; clr_status = 1'b0;
        wif.wr_valid = 1'b0; wif.wr_data = 5'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;
        step();

        // Single symbol: load 2 clk after push, underrun at done with empty queue.
        enable = 1'b1;
        push(5'h13);
        chk("t2_no_early_load", 32'(load), 0);
        step();
        chk("t2_load", 32'(load), 1);
        chk("t2_sym", 32'(sym), 32'h13);
        chk("t2_busy", 32'(busy), 1);
        wait_idle(200);
        chk("t2_underrun", 32'(underrun), 1);

        // Fill to full with enable low, drop a 9th, then drain in order.
        enable = 1'b0;
        pulse_clr();
        chk("t3_clr", 32'(underrun), 0);
        for (int i = 0; i < DEPTH; i++) push(5'($urandom_range(0, 16)));
        chk("t3_full_ready", 32'(wif.wr_ready), 0);
        chk("t3_full_level", 32'(level), DEPTH);
        push(5'($urandom_range(0, 16)));
        chk("t3_drop_level", 32'(level), DEPTH);
        lc0 = load_cnt;
        enable = 1'b1;
        step();
        n = 0;
        while (busy && n < 2000) begin
            chk("t3_underrun_early", 32'(underrun), 0);
            step();
            n++;
        end
        chk("t3_idle", 32'(busy), 0);
        chk("t3_underrun_last", 32'(underrun), 1);
        chk("t3_loads", 32'(load_cnt - lc0), DEPTH);

        // Push coinciding with a LOAD pop at level 3.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push(5'($urandom_range(0, 16)));
        chk("t4_level_pre", 32'(level), 3);
        enable = 1'b1;
        step();
        chk("t4_load", 32'(load), 1);
        wif.wr_valid = 1'b1;
        wif.wr_data  = 5'($urandom_range(0, 16));
        step();
        wif.wr_valid = 1'b0;
        enable = 1'b0;
        chk("t4_level_same", 32'(level), 3);
        wait_idle(200);
        chk("t4_level_idle", 32'(level), 3);

        // enable dropped mid-symbol: finish current, stop with 2 queued.
        chk("t6_underrun_pre", 32'(underrun), 1);
        lc0 = load_cnt;
        enable = 1'b1;
        step();
        chk("t6_load", 32'(load), 1);
        enable = 1'b0;
        wait_idle(200);
        chk("t6_level", 32'(level), 2);
        chk("t6_underrun_kept", 32'(underrun), 1);
        chk("t6_one_load", 32'(load_cnt - lc0), 1);
        pulse_clr();
        chk("t6_clr", 32'(underrun), 0);
        enable = 1'b1;
        step();
        wait_idle(400);
        chk("t6_drained", 32'(level), 0);
        chk("t6_underrun_end", 32'(underrun), 1);

        // Null symbol followed by another: reload timing after immediate done.
        enable = 1'b0;
        push(5'h10);
        push(5'h05);
        enable = 1'b1;
        step();
        chk("t5_load0", 32'(load), 1);
        chk("t5_sym0", 32'(sym), 32'h10);
        step();
        step();
        chk("t5_wait_busy", 32'(busy), 1);
        chk("t5_wait_noload", 32'(load), 0);
`ifdef IR_SEQ_GAP_EN
        step();
        chk("t5_gap_noload", 32'(load), 0);
        prev = bck;
        rises = 0;
        n = 0;
        while (!load && n < 4000) begin
            step();
            n++;
            if (bck && !prev) rises++;
            prev = bck;
        end
        chk("t5_gap_load", 32'(load), 1);
        chk("t5_gap_rises", 32'(rises), GAP_BCKS);
`else
        step();
        chk("t5_reload", 32'(load), 1);
        chk("t5_sym1", 32'(sym), 32'h05);
`endif
        wait_idle(400);
        chk("t5_underrun", 32'(underrun), 1);

        // Reset in the middle of WAIT with 3 symbols still queued.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(5'($urandom_range(0, 15)));
        enable = 1'b1;
        step();
        chk("t1_load", 32'(load), 1);
        step();
        step();
        chk("t1_level_wait", 32'(level), 3);
        chk("t1_busy_wait", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_reset_vals("t1_rst");
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_post_load", 32'(load), 0);
        end
        chk("t1_post_level", 32'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
